// File: rtl/aes_ctr_batch_sched.sv
// aes_ctr_batch_sched: CTR-mode batch scheduler for a multi-lane AES-256 keystream core.
// Issues NUM_LANES counter blocks per batch, collects keystream in issue order into a
// credit-managed output FIFO, tags each batch with a lane mask and a last flag.
// Optional build macro AES_CTR_SCHED_PERF_EN adds the perf_cycles[15:0] busy-cycle counter.
module aes_ctr_batch_sched #(
  parameter int NUM_LANES         = 3,
  parameter int BLOCK_W           = 128,
  parameter int CTR_W             = 6,
  parameter int XOF_TARGET_BLOCKS = 44,
  parameter int PRF_TARGET_BLOCKS = 8,
  parameter int OUT_DEPTH         = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           mode,
  input  logic [7:0]                     nonce_a,
  input  logic [7:0]                     nonce_b,
  output logic                           core_iv_valid,
  input  logic                           core_iv_ready,
  output logic [NUM_LANES*BLOCK_W-1:0]   core_iv,
  input  logic                           core_ks_valid,
  input  logic [NUM_LANES*BLOCK_W-1:0]   core_ks,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_LANES*BLOCK_W-1:0]   out_data,
  output logic [NUM_LANES-1:0]           out_lane_mask,
  output logic                           out_last,
  output logic                           busy,
  output logic                           finished,
  output logic                           err_overflow
`ifdef AES_CTR_SCHED_PERF_EN
  ,
  output logic [15:0]                    perf_cycles
`endif
);

  localparam int DATA_W   = NUM_LANES * BLOCK_W;
  localparam int NB_XOF   = (XOF_TARGET_BLOCKS + NUM_LANES - 1) / NUM_LANES;
  localparam int NB_PRF   = (PRF_TARGET_BLOCKS + NUM_LANES - 1) / NUM_LANES;
  localparam int NB_MAX   = (NB_XOF > NB_PRF) ? NB_XOF : NB_PRF;
  localparam int CNT_W    = $clog2(NB_MAX + 1);
  localparam int TAIL_XOF = XOF_TARGET_BLOCKS - (NB_XOF - 1) * NUM_LANES;
  localparam int TAIL_PRF = PRF_TARGET_BLOCKS - (NB_PRF - 1) * NUM_LANES;
  localparam int AW       = $clog2(OUT_DEPTH);
  localparam int FCW      = AW + 1;
  localparam int ENT_W    = DATA_W + NUM_LANES + 1;

  // Lanes below the tail count carry target blocks; MSB of the mask is lane 0.
  function automatic logic [NUM_LANES-1:0] tail_mask(input int tail);
    logic [NUM_LANES-1:0] m;
    m = '0;
    for (int j = 0; j < NUM_LANES; j++) m[NUM_LANES-1-j] = (j < tail);
    return m;
  endfunction

  localparam logic [NUM_LANES-1:0] MASK_XOF = tail_mask(TAIL_XOF);
  localparam logic [NUM_LANES-1:0] MASK_PRF = tail_mask(TAIL_PRF);

  // IV for every lane of one batch: {nonce_a, nonce_b, zeros, ctr}, lane 0 in the MSBs.
  function automatic logic [DATA_W-1:0] build_iv(input logic [CNT_W-1:0] batch,
                                                 input logic [7:0] na,
                                                 input logic [7:0] nb);
    logic [DATA_W-1:0]  iv;
    logic [BLOCK_W-1:0] lane;
    logic [CTR_W-1:0]   ctr;
    iv = '0;
    for (int j = 0; j < NUM_LANES; j++) begin
      ctr  = CTR_W'(32'(batch) * 32'(NUM_LANES) + 32'(j));
      lane = '0;
      lane[BLOCK_W-1 -: 8] = na;
      lane[BLOCK_W-9 -: 8] = nb;
      lane[CTR_W-1:0]      = ctr;
      iv[(NUM_LANES-1-j)*BLOCK_W +: BLOCK_W] = lane;
    end
    return iv;
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_mode;
  logic [7:0]         r_nonce_a;
  logic [7:0]         r_nonce_b;
  logic [CNT_W-1:0]   r_issued;
  logic [CNT_W-1:0]   r_received;
  logic [CNT_W-1:0]   r_popped;
  logic [DATA_W-1:0]  r_core_iv;
  logic               r_err;
  logic [ENT_W-1:0]   r_mem [OUT_DEPTH];
  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_rptr;
  logic [FCW-1:0]     r_count;

  logic               w_start;
  logic               w_active;
  logic [CNT_W-1:0]   w_nb;
  logic [CNT_W-1:0]   w_inflight;
  logic               w_xfer;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic               w_ent_last;
  logic [NUM_LANES-1:0] w_ent_mask;
  logic [DATA_W-1:0]  w_ent_data;
  logic [ENT_W-1:0]   w_head;

  assign w_start    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_active   = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_nb       = r_mode ? CNT_W'(NB_PRF) : CNT_W'(NB_XOF);
  assign w_inflight = r_issued - r_popped;
  assign w_full     = (r_count == FCW'(OUT_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_head     = r_mem[r_rptr];

  // A batch may only be issued while its result is guaranteed a FIFO slot.
  assign core_iv_valid = (r_state == S_RUN) && (r_issued < w_nb) &&
                         (32'(w_inflight) < 32'(OUT_DEPTH));
  assign w_xfer        = core_iv_valid && core_iv_ready;
  assign core_iv       = r_core_iv;

  assign out_valid     = !w_empty;
  assign w_pop         = out_valid && out_ready;
  // Pop frees a slot in the same cycle, so a push at full is still taken.
  assign w_push        = core_ks_valid && w_active && (!w_full || w_pop);
  assign w_drop        = core_ks_valid && !w_push;

  assign out_data      = out_valid ? w_head[ENT_W-1 -: DATA_W] : '0;
  assign out_lane_mask = out_valid ? w_head[NUM_LANES:1] : '0;
  assign out_last      = out_valid ? w_head[0] : 1'b0;

  assign busy          = w_active;
  assign finished      = (r_state == S_DONE);
  assign err_overflow  = r_err;

  // Tag the incoming keystream batch and zero the lanes past the target length.
  always_comb begin
    w_ent_last = (r_received == (w_nb - CNT_W'(1)));
    w_ent_mask = w_ent_last ? (r_mode ? MASK_PRF : MASK_XOF) : '1;
    w_ent_data = core_ks;
    for (int j = 0; j < NUM_LANES; j++) begin
      if (!w_ent_mask[NUM_LANES-1-j]) w_ent_data[(NUM_LANES-1-j)*BLOCK_W +: BLOCK_W] = '0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: issue until NB batches accepted, then drain until the last pop.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_xfer && ((r_issued + CNT_W'(1)) == w_nb)) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_pop && w_head[0]) w_state_nxt = S_DONE;
      S_DONE:  if (start) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request configuration latched on an honoured start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode    <= 1'b0;
      r_nonce_a <= '0;
      r_nonce_b <= '0;
    end else if (w_start) begin
      r_mode    <= mode;
      r_nonce_a <= nonce_a;
      r_nonce_b <= nonce_b;
    end
  end

  // Issue / receive / pop counters; they never wrap within one request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issued   <= '0;
      r_received <= '0;
      r_popped   <= '0;
    end else if (w_start) begin
      r_issued   <= '0;
      r_received <= '0;
      r_popped   <= '0;
    end else begin
      if (w_xfer) r_issued   <= r_issued + CNT_W'(1);
      if (w_push) r_received <= r_received + CNT_W'(1);
      if (w_pop)  r_popped   <= r_popped + CNT_W'(1);
    end
  end

  // IV register: batch 0 on start, next batch after each accepted transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_core_iv <= '0;
    else if (w_start) r_core_iv <= build_iv('0, nonce_a, nonce_b);
    else if (w_xfer)  r_core_iv <= build_iv(r_issued + CNT_W'(1), r_nonce_a, r_nonce_b);
  end

  // FIFO storage; contents are only visible through the valid-gated head.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {w_ent_data, w_ent_mask, w_ent_last};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_start) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + FCW'(1);
        2'b01:   r_count <= r_count - FCW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow flag: a dropped keystream batch sets it, a new request clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_err <= 1'b0;
    else if (w_drop)  r_err <= 1'b1;
    else if (w_start) r_err <= 1'b0;
  end

`ifdef AES_CTR_SCHED_PERF_EN
  logic [15:0] r_perf;

  // Busy-cycle counter, saturating, frozen once the request completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           r_perf <= '0;
    else if (w_start)                     r_perf <= '0;
    else if (w_active && (r_perf != '1))  r_perf <= r_perf + 16'd1;
  end

  assign perf_cycles = r_perf;
`endif

endmodule

// File: tb/tb_aes_ctr_batch_sched.sv
// Directed bench for aes_ctr_batch_sched with default parameters (3 lanes, 128-bit blocks).
// A behavioural core echoes each IV batch back as keystream after 7 cycles.
module tb_aes_ctr_batch_sched;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [7:0]   nonce_a = '0;
  logic [7:0]   nonce_b = '0;
  logic         core_iv_valid;
  logic         core_iv_ready = 1'b1;
  logic [383:0] core_iv;
  logic         core_ks_valid;
  logic [383:0] core_ks;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [383:0] out_data;
  logic [2:0]   out_lane_mask;
  logic         out_last;
  logic         busy;
  logic         finished;
  logic         err_overflow;

  int n_tests = 0;
  int n_fail  = 0;

  aes_ctr_batch_sched dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .mode          (mode),
    .nonce_a       (nonce_a),
    .nonce_b       (nonce_b),
    .core_iv_valid (core_iv_valid),
    .core_iv_ready (core_iv_ready),
    .core_iv       (core_iv),
    .core_ks_valid (core_ks_valid),
    .core_ks       (core_ks),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_lane_mask (out_lane_mask),
    .out_last      (out_last),
    .busy          (busy),
    .finished      (finished),
    .err_overflow  (err_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [383:0] got, input logic [383:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  // Expected IV batch b: lane j = {na, nb, 0..., (3b+j) mod 64}, lane 0 in the MSBs.
  function automatic logic [383:0] exp_iv(input int b, input logic [7:0] na, input logic [7:0] nb);
    logic [383:0] v;
    logic [127:0] lane;
    v = '0;
    for (int j = 0; j < 3; j++) begin
      lane = '0;
      lane[127:120] = na;
      lane[119:112] = nb;
      lane[5:0]     = 6'((b * 3 + j) % 64);
      v[(2-j)*128 +: 128] = lane;
    end
    return v;
  endfunction

  // Core model: echo each accepted IV batch 7 cycles later, in order.
  int           cyc = 0;
  int           q_t[$];
  logic [383:0] q_d[$];
  logic         m_vld = 1'b0;
  logic [383:0] m_data = '0;
  logic         inj_vld = 1'b0;
  logic [383:0] inj_data = '0;

  assign core_ks_valid = m_vld | inj_vld;
  assign core_ks       = inj_vld ? inj_data : m_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      q_t.delete();
      q_d.delete();
      m_vld = 1'b0;
    end else begin
      cyc++;
      if (core_iv_valid && core_iv_ready) begin
        q_t.push_back(cyc + 7);
        q_d.push_back(core_iv);
      end
      m_vld = 1'b0;
      if (q_t.size() > 0 && q_t[0] == cyc) begin
        m_vld  = 1'b1;
        m_data = q_d.pop_front();
        void'(q_t.pop_front());
      end
    end
  end

  // Monitor: checks every issued IV and every popped output batch.
  int          n_iss = 0;
  int          n_pop = 0;
  logic        fin_pend = 1'b0;
  logic        exp_mode = 1'b0;
  logic [7:0]  exp_na = '0;
  logic [7:0]  exp_nb = '0;

  always @(negedge clk) begin
    int           nb;
    logic         lst;
    logic [383:0] d;
    if (fin_pend) begin
      chk("finished_after_last_pop", finished, 1'b1);
      chk("busy_after_last_pop", busy, 1'b0);
      fin_pend = 1'b0;
    end
    if (rst_n) begin
      if (core_iv_valid && core_iv_ready) begin
        chk("issued_iv", core_iv, exp_iv(n_iss, exp_na, exp_nb));
        n_iss++;
      end
      if (out_valid && out_ready) begin
        nb  = exp_mode ? 3 : 15;
        lst = (n_pop == nb - 1);
        d   = exp_iv(n_pop, exp_na, exp_nb);
        if (lst) d[127:0] = '0;
        chk("pop_data", out_data, d);
        chk("pop_mask", out_lane_mask, lst ? 3'b110 : 3'b111);
        chk("pop_last", out_last, lst);
        if (out_last) fin_pend = 1'b1;
        n_pop++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic m, input logic [7:0] a, input logic [7:0] b);
    exp_mode = m;
    exp_na   = a;
    exp_nb   = b;
    n_iss    = 0;
    n_pop    = 0;
    mode     = m;
    nonce_a  = a;
    nonce_b  = b;
    start    = 1'b1;
    step(1);
    start    = 1'b0;
    mode     = ~m;
    nonce_a  = 8'hFF;
    nonce_b  = 8'hEE;
  endtask

  task automatic wait_fin(input int budget, input string tag);
    int k;
    k = 0;
    while (!finished && k < budget) begin
      step(1);
      k++;
    end
    chk(tag, finished, 1'b1);
  endtask

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_finished", finished, 1'b0);
    chk("rst_iv_valid", core_iv_valid, 1'b0);
    chk("rst_iv", core_iv, '0);
    chk("rst_err", err_overflow, 1'b0);
    step(3);
    rst_n = 1'b1;
    step(1);

    // PRF request, free-flowing output
    do_start(1'b1, 8'hA5, 8'h3C);
    chk("prf_busy", busy, 1'b1);
    wait_fin(200, "prf_done");
    chk("prf_pops", n_pop, 3);
    chk("prf_issues", n_iss, 3);
    chk("prf_err", err_overflow, 1'b0);
    chk("prf_fifo_empty", out_valid, 1'b0);
    step(2);

    // XOF request from DONE, free-flowing output
    do_start(1'b0, 8'h12, 8'h34);
    wait_fin(400, "xof_done");
    chk("xof_pops", n_pop, 15);
    chk("xof_issues", n_iss, 15);
    step(2);

    // XOF with the consumer stalled: issue stops at the credit limit
    out_ready = 1'b0;
    do_start(1'b0, 8'h77, 8'h88);
    step(40);
    chk("stall_issues", n_iss, 4);
    chk("stall_iv_valid", core_iv_valid, 1'b0);
    chk("stall_out_valid", out_valid, 1'b1);
    chk("stall_busy", busy, 1'b1);
    chk("stall_err", err_overflow, 1'b0);
    out_ready = 1'b1;
    wait_fin(400, "stall_done");
    chk("stall_pops", n_pop, 15);
    chk("stall_issues_total", n_iss, 15);
    chk("stall_err_end", err_overflow, 1'b0);
    step(2);

    // start pulse during RUN is ignored; start in DONE restarts counters
    do_start(1'b1, 8'h11, 8'h22);
    step(2);
    mode    = 1'b0;
    nonce_a = 8'h33;
    nonce_b = 8'h44;
    start   = 1'b1;
    step(1);
    start   = 1'b0;
    chk("ignored_start_busy", busy, 1'b1);
    wait_fin(200, "ignored_start_done");
    chk("ignored_start_pops", n_pop, 3);
    chk("ignored_start_issues", n_iss, 3);
    step(1);
    do_start(1'b1, 8'h55, 8'h66);
    chk("restart_busy", busy, 1'b1);
    chk("restart_finished", finished, 1'b0);
    wait_fin(200, "restart_done");
    chk("restart_pops", n_pop, 3);

    // Reset in DRAIN with two batches buffered
    step(1);
    out_ready = 1'b0;
    do_start(1'b1, 8'h5A, 8'hC3);
    step(20);
    chk("drain_out_valid", out_valid, 1'b1);
    chk("drain_iv_valid", core_iv_valid, 1'b0);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    chk("drain_one_pop", n_pop, 1);
    chk("drain_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_finished", finished, 1'b0);
    chk("midrst_last", out_last, 1'b0);
    step(2);
    rst_n = 1'b1;
    step(2);
    chk("postrst_busy", busy, 1'b0);
    chk("postrst_out_valid", out_valid, 1'b0);
    chk("postrst_finished", finished, 1'b0);
    chk("postrst_iv_valid", core_iv_valid, 1'b0);

    // Keystream arriving in IDLE is dropped and flagged until the next start
    inj_data = {3{128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F1E_2D3C}};
    inj_vld  = 1'b1;
    step(1);
    inj_vld  = 1'b0;
    chk("inj_err", err_overflow, 1'b1);
    chk("inj_fifo_empty", out_valid, 1'b0);
    step(2);
    chk("inj_err_sticky", err_overflow, 1'b1);
    out_ready = 1'b1;
    do_start(1'b1, 8'h01, 8'h02);
    chk("start_clears_err", err_overflow, 1'b0);
    wait_fin(200, "post_inj_done");
    chk("post_inj_pops", n_pop, 3);
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_ctr_batch_sched.md
Name: aes_ctr_batch_sched

Overview:
Parametrised CTR-mode batch scheduler for the AES-256 keystream generator. It issues NUM_LANES counter blocks per batch to an external multi-lane AES round pipeline and collects the returned keystream in order. Results are buffered in a credit-managed output FIFO with valid/ready backpressure, and completion is signalled for XOF or PRF target lengths. It sits between the sampler/hash consumers and the unrolled AES cores; round-key handling stays inside the core.

Parameters:
NUM_LANES, 3, parallel AES lanes per batch (1..8)
BLOCK_W, 128, AES block width
CTR_W, 6, counter field width in IV LSBs
XOF_TARGET_BLOCKS, 44, blocks to produce in mode 0
PRF_TARGET_BLOCKS, 8, blocks to produce in mode 1
OUT_DEPTH, 4, output FIFO depth in batches (power of 2, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; honoured in IDLE/DONE only
mode  in  1  0 = XOF, 1 = PRF; sampled with start
nonce_a  in  8  nonce byte A; sampled with start
nonce_b  in  8  nonce byte B; sampled with start
core_iv_valid  out  1  batch of IVs offered to core
core_iv_ready  in  1  core accepts batch this cycle
core_iv  out  NUM_LANES*BLOCK_W  lane0 in MSBs
core_ks_valid  in  1  keystream batch returned (in issue order)
core_ks  in  NUM_LANES*BLOCK_W  keystream, lane0 in MSBs
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
out_data  out  NUM_LANES*BLOCK_W  keystream batch; masked lanes forced 0
out_lane_mask  out  NUM_LANES  1 = lane carries a target block; MSB = lane0
out_last  out  1  head is final batch of request
busy  out  1  state RUN or DRAIN
finished  out  1  high in DONE
err_overflow  out  1  sticky: core_ks_valid with FIFO full or outside RUN/DRAIN

Behaviour:
- Reset (any time, incl. mid-request): state IDLE; all counters, FIFO pointers, mask/last tags, err_overflow cleared; all outputs 0.
- T = mode ? PRF_TARGET_BLOCKS : XOF_TARGET_BLOCKS; NB = ceil(T/NUM_LANES), computed from registered mode.
- IV lane j of batch b: {nonce_a, nonce_b, zeros, ctr}, ctr = (b*NUM_LANES + j) mod 2^CTR_W in low CTR_W bits.
- States: IDLE -start-> RUN; RUN -(issued==NB on accepted transfer)-> DRAIN; DRAIN -(last batch popped)-> DONE; DONE -start-> RUN. start ignored in RUN/DRAIN.
- On start: latch mode and nonces; clear issued, received, popped.
- core_iv_valid = RUN && issued<NB && (issued-popped)<OUT_DEPTH (credit check, combinational). core_iv is registered from the issue counter and holds until the transfer completes.
- Transfer occurs when core_iv_valid && core_iv_ready; issued increments; core_iv advances next cycle.
- core_ks_valid in RUN/DRAIN with FIFO not full: push {core_ks, mask, last}. received increments. last = (received==NB-1).
- Mask: all ones, except on the last batch, where lanes j >= T-(NB-1)*NUM_LANES are 0. Masked lanes are stored as 0.
- Error case: core_ks_valid with FIFO full, or in IDLE/DONE: entry dropped, err_overflow set (sticky until reset or start).
- out_valid = FIFO non-empty. Push-to-out_valid latency is 1 cycle.
- Pop on out_valid && out_ready; popped increments.
- Simultaneous push and pop at full: pop is taken first and the push is accepted.
- finished: rises the cycle after the out_last pop; holds until start.
- Counter widths: clog2(NB_max+1) bits; no wrap within a request.

Optional Feature:
AES_CTR_SCHED_PERF_EN: adds output port perf_cycles[15:0].
- Cleared on start; increments each cycle while busy; saturates at 16'hFFFF; holds in DONE.
- Without the macro: port and counter absent; all other behaviour identical.

Test Plan:
- PRF, nonce_a=8'hA5, nonce_b=8'h3C, core_iv_ready=1, core echoes with 7-cycle latency, out_ready=1 -> 3 batches with ctr {0,1,2},{3,4,5},{6,7,8}; last batch out_lane_mask=3'b110 with lane2 data 0, out_last=1; finished=1 next cycle.
- XOF, same core, out_ready=1 -> 15 batches (44 blocks), last mask 3'b110, IV ctr 44 issued but not counted; exactly 15 pops.
- XOF, out_ready=0 -> exactly 4 issues (OUT_DEPTH credits), core_iv_valid low after that. out_ready=1 resumes issue; no err_overflow.
- Pulse start during RUN -> ignored; mode and nonce unchanged; second start in DONE launches new request with counter restarting at 0.
- Drop rst_n mid-DRAIN with 2 entries buffered -> out_valid=0, busy=0, finished=0 immediately; after release, state IDLE.
- Inject core_ks_valid in IDLE -> err_overflow=1 and FIFO empty; next start clears it.
